wbm_copy: RTL and testbench

WBM_COPY -- requirements
Module: wbm_copy

---
 rtl/wbm_pkg.sv | 21 ++
 rtl/wbm_copy_timeout.sv | 40 ++++
 rtl/wbm_copy.sv | 172 +++++++++++++++++
 tb/tb_wbm_copy.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared definitions for the wbm_copy Wishbone word-copy engine:
// FSM state encoding, bus constants and the address alignment helper.
package wbm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_RGAP  = 3'd2,
      ST_WRITE = 3'd3,
      ST_WGAP  = 3'd4,
      ST_DONE  = 3'd5
   } wbm_state_e;

   localparam logic [3:0]  WB_SEL_ALL = 4'hF;
   localparam logic [31:0] WORD_STEP  = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] byte_adr);
      return byte_adr & ~32'h3;
   endfunction

endpackage

// File: rtl/wbm_copy_timeout.sv
// Wait-cycle watchdog for wbm_copy: counts cycles spent waiting for an ack
// and flags the last permitted wait cycle.
module wbm_copy_timeout
   import wbm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // expired is high during the TIMEOUT_CYCLES-th consecutive wait cycle
   assign expired = enable && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wbm_copy.sv
// Wishbone initiator that copies len 32-bit words from src_adr to dst_adr,
// one read then one write per word. Optional ack timeout: CFG_WBM_TIMEOUT_EN.
module wbm_copy
   import wbm_pkg::*;
#(
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [31:0]          src_adr,
   input  logic [31:0]          dst_adr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [31:0]          wb_dat_o,
   output logic [3:0]           wb_sel_o,
   input  logic [31:0]          wb_dat_i,
   input  logic                 wb_ack_i
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("wbm_copy: TIMEOUT_CYCLES must be at least 1");
   end

   wbm_state_e           state_q, state_d;
   logic [31:0]          src_q, src_d;
   logic [31:0]          dst_q, dst_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic                 cyc_q, cyc_d;
   logic                 stb_q, stb_d;
   logic                 we_q, we_d;
   logic [31:0]          adr_q, adr_d;
   logic [31:0]          dat_q, dat_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 timeout_hit;

`ifdef CFG_WBM_TIMEOUT_EN
   logic waiting;
   logic error_q, error_d;

   assign waiting = (state_q == ST_READ) || (state_q == ST_WRITE);

   wbm_copy_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .clear   (!waiting),
      .enable  (waiting && !wb_ack_i),
      .expired (timeout_hit)
   );

   always_comb begin
      error_d = timeout_hit;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      dat_d   = dat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d   = word_align(src_adr);
               dst_d   = word_align(dst_adr);
               rem_d   = len;
               state_d = (len == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (wb_ack_i) begin
               dat_d   = wb_dat_i;
               state_d = ST_RGAP;
            end else if (timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_RGAP: state_d = ST_WRITE;
         ST_WRITE: begin
            if (wb_ack_i) begin
               src_d   = src_q + WORD_STEP;
               dst_d   = dst_q + WORD_STEP;
               rem_d   = rem_q - LEN_WIDTH'(1);
               state_d = ST_WGAP;
            end else if (timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_WGAP: state_d = (rem_q == '0) ? ST_DONE : ST_READ;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bus outputs are decoded from the next state so they leave the flops
      // already aligned with the state they belong to.
      cyc_d  = (state_d == ST_READ) || (state_d == ST_WRITE);
      stb_d  = cyc_d;
      we_d   = (state_d == ST_WRITE);
      adr_d  = adr_q;
      if (state_d == ST_READ) begin
         adr_d = src_d;
      end else if (state_d == ST_WRITE) begin
         adr_d = dst_d;
      end
      busy_d = (state_d == ST_READ) || (state_d == ST_RGAP) ||
               (state_d == ST_WRITE) || (state_d == ST_WGAP);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = stb_q ? WB_SEL_ALL : '0;

endmodule

// File: tb/tb_wbm_copy.sv
// Self-checking bench for wbm_copy: table of copy jobs, memory-model
// responder with scoreboard, plus reset-mid-write and timeout sequences.
module tb_wbm_copy;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_adr = '0;
   logic [31:0] dst_adr = '0;
   logic [15:0] len = '0;
   logic        busy, done, err;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;
   xfer_t sb[$];

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      int          lat;
      int          exp_edges;
   } vec_t;

   int   lat = 1;
   bit   ack_en = 1'b1;
   int   seen_cnt = 0;
   logic [31:0] held_adr = '0;

   wbm_copy #(
      .LEN_WIDTH(16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .start    (start),
      .src_adr  (src_adr),
      .dst_adr  (dst_adr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .error    (err),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // Responder: acks after `lat` full stb cycles, checks each transfer
   // against the scoreboard and that cyc is low in the cycle after an ack.
   always @(negedge clk) begin
      if (rst) begin
         wb_ack_i = 1'b0;
         seen_cnt = 0;
      end else if (wb_ack_i) begin
         wb_ack_i = 1'b0;
         seen_cnt = 0;
         wb_dat_i = $urandom;
         chk("cyc_after_ack", {31'd0, wb_cyc_o}, 32'd0);
      end else if (wb_cyc_o && wb_stb_o) begin
         if (seen_cnt == 0) held_adr = wb_adr_o;
         if (ack_en && seen_cnt >= lat) begin
            chk("sel", {28'd0, wb_sel_o}, 32'hF);
            chk("adr_stable", wb_adr_o, held_adr);
            if (sb.size() == 0) begin
               chk("unexpected_xfer_adr", wb_adr_o, 32'hFFFF_FFFF);
            end else begin
               xfer_t e;
               e = sb.pop_front();
               chk("xfer_we", {31'd0, wb_we_o}, {31'd0, e.we});
               chk("xfer_adr", wb_adr_o, e.adr);
               if (e.we) chk("xfer_wdat", wb_dat_o, e.dat);
               else      wb_dat_i = mem_word(wb_adr_o);
            end
            wb_ack_i = 1'b1;
         end else begin
            seen_cnt++;
            wb_dat_i = $urandom;
         end
      end
   end

   task automatic push_copy(input logic [31:0] s_in, input logic [31:0] d_in, input logic [15:0] n);
      logic [31:0] s, d;
      xfer_t t;
      s = s_in & 32'hFFFF_FFFC;
      d = d_in & 32'hFFFF_FFFC;
      for (int i = 0; i < int'(n); i++) begin
         t.we = 1'b0; t.adr = s + 32'(4 * i); t.dat = '0;
         sb.push_back(t);
         t.we = 1'b1; t.adr = d + 32'(4 * i); t.dat = mem_word(s + 32'(4 * i));
         sb.push_back(t);
      end
   endtask

   task automatic issue_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(negedge clk);
      start = 1'b1; src_adr = s; dst_adr = d; len = n;
      @(posedge clk);
      #1;
      start = 1'b0;
      src_adr = $urandom; dst_adr = $urandom; len = 16'($urandom);
   endtask

   task automatic run_copy(input vec_t v);
      int edges;
      lat = v.lat;
      ack_en = 1'b1;
      push_copy(v.src, v.dst, v.len);
      issue_start(v.src, v.dst, v.len);
      chk("busy_after_accept", {31'd0, busy}, {31'd0, (v.len != 0)});
      edges = 0;
      while (!done && edges < 2000) begin
         start = (edges == 2);
         if (edges == 2) len = 16'd5;
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      chk("done_edges", edges, v.exp_edges);
      chk("error_at_done", {31'd0, err}, 32'd0);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_done", {30'd0, busy, wb_cyc_o}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int cnt;
      int cyc_cycles;

      vecs[0] = '{src: 32'h0000_0100, dst: 32'h0000_1000, len: 16'd1, lat: 1, exp_edges: 6};
      vecs[1] = '{src: 32'h0000_0000, dst: 32'h0000_0800, len: 16'd4, lat: 1, exp_edges: 24};
      vecs[2] = '{src: 32'h0000_0200, dst: 32'h0000_0300, len: 16'd0, lat: 1, exp_edges: 0};
      vecs[3] = '{src: 32'hFFFF_FFFC, dst: 32'h0000_0040, len: 16'd2, lat: 1, exp_edges: 12};
      vecs[4] = '{src: 32'h0000_0013, dst: 32'h0000_2002, len: 16'd3, lat: 3, exp_edges: 30};
      vecs[5] = '{src: 32'h0000_0040, dst: 32'hFFFF_FFF8, len: 16'd3, lat: 2, exp_edges: 24};
      vecs[6] = '{src: 32'h0000_0700, dst: 32'h0000_0900, len: 16'd3, lat: 1, exp_edges: 18};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {26'd0, wb_cyc_o, wb_stb_o, wb_we_o, busy, done, err}, 32'd0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_copy(vecs[i]);

      // Reset asserted while a write is waiting for its ack.
      lat = 5;
      push_copy(32'h500, 32'h600, 16'd2);
      issue_start(32'h500, 32'h600, 16'd2);
      cnt = 0;
      while (!(wb_we_o && wb_stb_o) && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("reached_write", {31'd0, wb_we_o && wb_stb_o}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      chk("async_rst_sel", {28'd0, wb_sel_o}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      run_copy(vecs[6]);

`ifdef CFG_WBM_TIMEOUT_EN
      // Responder never acks: abort after 8 wait cycles with error.
      ack_en = 1'b0;
      issue_start(32'h40, 32'h80, 16'd3);
      cnt = 0;
      cyc_cycles = 0;
      while (!done && cnt < 200) begin
         if (wb_cyc_o) cyc_cycles++;
         start = (cnt == 3);
         if (cnt == 3) len = 16'd1;
         @(posedge clk);
         #1;
         cnt++;
      end
      start = 1'b0;
      chk("to_done_edges", cnt, 32'd8);
      chk("to_cyc_cycles", cyc_cycles, 32'd8);
      chk("to_error", {31'd0, err}, 32'd1);
      chk("to_cyc_at_done", {31'd0, wb_cyc_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("to_idle_after", {29'd0, busy, wb_cyc_o, err}, 32'd0);
      ack_en = 1'b1;
`else
      // Long ack latency waits indefinitely when no timeout is built in.
      begin
         vec_t slow;
         slow = '{src: 32'h0000_0C00, dst: 32'h0000_0D00, len: 16'd1, lat: 12, exp_edges: 28};
         run_copy(slow);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
